// File: rtl/csoc_scan_ctrl.sv
// csoc_scan_ctrl: UART byte-command scan-chain controller driving CSoC test pins.
// Define CSOC_SCAN_LOOPBACK_EN to capture from csoc_data_o instead of csoc_data_i.
module csoc_scan_ctrl #(
  parameter int CHAINS  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic              csoc_clk,
  output logic              csoc_rstn,
  output logic              csoc_test_se,
  output logic              csoc_test_tm,
  output logic [CHAINS-1:0] csoc_data_o,
  input  logic [CHAINS-1:0] csoc_data_i,
  output logic              busy,
  output logic              overrun
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARG  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_HI   = 3'd4;
  localparam logic [2:0] S_SEND = 3'd5;
  logic [2:0]        r_state;
  logic [1:0]        r_op;
  logic              r_hi_arg;
  logic [15:0]       r_cnt;
  logic [PW-1:0]     r_phase;
  logic [CHAINS-1:0] r_cap;
  logic [CHAINS-1:0] r_data_o;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic              r_clk;
  logic              r_rstn_o;
  logic              r_se;
  logic              r_tm;
  logic              r_overrun;
  logic [CHAINS-1:0] w_cap_src;
  logic [15:0]       w_n;
  logic [15:0]       w_cnt_dec;
  logic              w_ph_last;
  logic              w_drop;
  logic              w_op_arg;
`ifdef CSOC_SCAN_LOOPBACK_EN
  logic w_unused_data_i;
  assign w_unused_data_i = ^csoc_data_i;
  assign w_cap_src = r_data_o;
`else
  assign w_cap_src = csoc_data_i;
`endif
  assign w_n       = {r_cnt[15:8], rx_data};
  assign w_cnt_dec = r_cnt - 16'd1;
  assign w_ph_last = r_phase == PH_LAST;
  assign w_op_arg  = rx_data == 8'h01 || rx_data == 8'h02 || rx_data == 8'h03;
  assign w_drop    = rx_valid && (r_state == S_LO || r_state == S_HI || r_state == S_SEND);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_op       <= 2'd0;
      r_hi_arg   <= 1'b0;
      r_cnt      <= 16'd0;
      r_phase    <= '0;
      r_cap      <= '0;
      r_data_o   <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_clk      <= 1'b0;
      r_rstn_o   <= 1'b0;
      r_se       <= 1'b0;
      r_tm       <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (w_drop) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (rx_valid) begin
          r_op     <= w_op_arg ? rx_data[1:0] : 2'd0;
          r_hi_arg <= rx_data != 8'h01;
          if (w_op_arg) r_state <= S_ARG;
          else begin
            r_state   <= S_SEND;
            r_tx_data <= rx_data == 8'h04 ? {r_overrun, 4'b0, r_rstn_o, r_se, r_tm} : 8'hEE;
            if (rx_data == 8'h04) r_overrun <= 1'b0;
          end
        end
        S_ARG: if (rx_valid) begin
          r_hi_arg <= 1'b0;
          if (r_hi_arg) r_cnt[15:8] <= rx_data;
          else if (r_op == 2'd1) begin
            {r_rstn_o, r_se, r_tm} <= rx_data[2:0];
            r_tx_data <= 8'hA5;
            r_state   <= S_SEND;
          end else begin
            r_cnt   <= w_n;
            r_phase <= '0;
            r_state <= w_n == 16'd0 ? S_SEND : r_op == 2'd2 ? S_WAIT : S_LO;
            if (w_n == 16'd0) r_tx_data <= 8'hA5;
          end
        end
        S_WAIT: if (rx_valid) begin
          r_data_o <= rx_data[CHAINS-1:0];
          r_phase  <= '0;
          r_state  <= S_LO;
        end
        // capture lands on the same edge that raises csoc_clk
        S_LO: begin
          r_phase <= w_ph_last ? '0 : r_phase + 1'b1;
          if (w_ph_last) begin
            r_clk   <= 1'b1;
            r_cap   <= w_cap_src;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          r_phase <= w_ph_last ? '0 : r_phase + 1'b1;
          if (w_ph_last) begin
            r_clk <= 1'b0;
            r_cnt <= w_cnt_dec;
            if (r_op == 2'd2) begin
              r_tx_data <= 8'(r_cap);
              r_state   <= S_SEND;
            end else if (w_cnt_dec == 16'd0) begin
              r_tx_data <= 8'hA5;
              r_state   <= S_SEND;
            end else r_state <= S_LO;
          end
        end
        S_SEND: if (tx_ready) begin
          r_tx_start <= 1'b1;
          r_state    <= r_op == 2'd2 && r_cnt != 16'd0 ? S_WAIT : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign tx_data      = r_tx_data;
  assign tx_start     = r_tx_start;
  assign csoc_clk     = r_clk;
  assign csoc_rstn    = r_rstn_o;
  assign csoc_test_se = r_se;
  assign csoc_test_tm = r_tm;
  assign csoc_data_o  = r_data_o;
  assign busy         = r_state != S_IDLE;
  assign overrun      = r_overrun;
endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// tb_csoc_scan_ctrl: directed self-checking bench for csoc_scan_ctrl (CHAINS=4, CLK_DIV=2).
module tb_csoc_scan_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [3:0] csoc_data_i = 4'hA;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       csoc_clk;
  logic       csoc_rstn;
  logic       csoc_test_se;
  logic       csoc_test_tm;
  logic [3:0] csoc_data_o;
  logic       busy;
  logic       overrun;
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int pulses = 0;
  int rise_at = 0;
  int hi_w = 0;
  int per = 0;
  logic ck_q = 1'b0;
  logic [3:0] do_at_rise = 4'h0;

  csoc_scan_ctrl #(.CHAINS(4), .CLK_DIV(2)) u_dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // csoc_clk edge bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    ck_q <= csoc_clk;
    if (csoc_clk && !ck_q) begin
      pulses     <= pulses + 1;
      per        <= ncyc - rise_at;
      rise_at    <= ncyc;
      do_at_rise <= csoc_data_o;
    end
    if (!csoc_clk && ck_q) hi_w <= ncyc - rise_at;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_reply(input int budget, output logic [7:0] d, output int lat, output bit seen);
    seen = 1'b0;
    d    = 8'h00;
    lat  = 1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (tx_start) begin
        seen = 1'b1;
        d    = tx_data;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d; int lat; bit seen;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_data_o, tx_data, tx_start, busy, overrun} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got clk/rstn/se/tm=%b%b%b%b do=%h tx=%h start=%b busy=%b ovr=%b, expected all 0",
               csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_data_o, tx_data, tx_start, busy, overrun);
    end
    rstn = 1'b1;
    send_byte(8'h04);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h (seen %0d), expected 00", d, seen); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL reply_latency: got %0d cycles, expected 2", lat); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_width: still %b one cycle later, expected 0", tx_start); end
  endtask

  task automatic test_mode;
    logic [7:0] d; int lat; bit seen;
    send_byte(8'h01);
    send_byte(8'h07);
    checks++;
    if ({csoc_rstn, csoc_test_se, csoc_test_tm} !== 3'b111) begin
      errors++; $display("FAIL mode_pins: got %b, expected 111", {csoc_rstn, csoc_test_se, csoc_test_tm});
    end
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'hA5) begin errors++; $display("FAIL mode_reply: got %h (seen %0d), expected a5", d, seen); end
    send_byte(8'h04);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'h07) begin errors++; $display("FAIL mode_status: got %h (seen %0d), expected 07", d, seen); end
  endtask

  task automatic test_shift;
    logic [7:0] d; int lat; bit seen; int p0;
    logic [7:0] exp1, exp2;
`ifdef CSOC_SCAN_LOOPBACK_EN
    exp1 = 8'h0C; exp2 = 8'h05;
`else
    exp1 = 8'h0A; exp2 = 8'h0A;
`endif
    p0 = pulses;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h3C);
    wait_reply(40, d, lat, seen);
    checks++;
    if (!seen || d !== exp1) begin errors++; $display("FAIL shift_reply1: got %h (seen %0d), expected %h", d, seen, exp1); end
    checks++;
    if (do_at_rise !== 4'hC) begin errors++; $display("FAIL shift_data1: csoc_data_o at pulse %h, expected c", do_at_rise); end
    checks++;
    if (hi_w !== 2) begin errors++; $display("FAIL shift_high_width: %0d cycles, expected 2", hi_w); end
    send_byte(8'h05);
    wait_reply(40, d, lat, seen);
    checks++;
    if (!seen || d !== exp2) begin errors++; $display("FAIL shift_reply2: got %h (seen %0d), expected %h", d, seen, exp2); end
    checks++;
    if (do_at_rise !== 4'h5) begin errors++; $display("FAIL shift_data2: csoc_data_o at pulse %h, expected 5", do_at_rise); end
    checks++;
    if (pulses - p0 !== 2) begin errors++; $display("FAIL shift_pulses: %0d, expected 2", pulses - p0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL shift_idle: busy=%b, expected 0", busy); end
`ifdef CSOC_SCAN_LOOPBACK_EN
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hFF);
    wait_reply(40, d, lat, seen);
    checks++;
    if (!seen || d !== 8'h0F) begin errors++; $display("FAIL loopback_ff: got %h (seen %0d), expected 0f", d, seen); end
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h05);
    wait_reply(40, d, lat, seen);
`endif
  endtask

  task automatic test_pulse;
    logic [7:0] d; int lat; bit seen; int p0;
    p0 = pulses;
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    repeat (20) @(negedge clk);
    send_byte(8'h55);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, expected 1", overrun); end
    wait_reply(1200, d, lat, seen);
    checks++;
    if (!seen || d !== 8'hA5) begin errors++; $display("FAIL pulse_reply: got %h (seen %0d), expected a5", d, seen); end
    checks++;
    if (pulses - p0 !== 256) begin errors++; $display("FAIL pulse_count: %0d, expected 256", pulses - p0); end
    checks++;
    if (per !== 4) begin errors++; $display("FAIL pulse_period: %0d cycles, expected 4", per); end
    checks++;
    if (csoc_data_o !== 4'h5) begin errors++; $display("FAIL pulse_data_hold: %h, expected 5", csoc_data_o); end
    send_byte(8'h04);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'h87) begin errors++; $display("FAIL status_overrun: got %h (seen %0d), expected 87", d, seen); end
    send_byte(8'h04);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'h07) begin errors++; $display("FAIL status_cleared: got %h (seen %0d), expected 07", d, seen); end
  endtask

  task automatic test_boundary;
    logic [7:0] d; int lat; bit seen; int p0;
    send_byte(8'h7F);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'hEE) begin errors++; $display("FAIL bad_opcode: got %h (seen %0d), expected ee", d, seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bad_opcode_idle: busy=%b, expected 0", busy); end
    p0 = pulses;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'hA5) begin errors++; $display("FAIL shift_zero: got %h (seen %0d), expected a5", d, seen); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL shift_zero_latency: %0d cycles, expected 2", lat); end
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'hA5) begin errors++; $display("FAIL pulse_zero: got %h (seen %0d), expected a5", d, seen); end
    checks++;
    if (pulses - p0 !== 0) begin errors++; $display("FAIL zero_no_pulses: %0d, expected 0", pulses - p0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d; int lat; bit seen;
    send_byte(8'h04);
    wait_reply(10, d, lat, seen);
    rx_data  = 8'h7F;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'hEE) begin errors++; $display("FAIL b2b_accept: got %h (seen %0d), expected ee", d, seen); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
  endtask

  task automatic test_reset_abort;
    logic [7:0] d; int lat; bit seen; int starts;
    starts = 0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h3C);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_data_o, tx_data, tx_start, busy, overrun} !== 19'd0) begin
      errors++;
      $display("FAIL abort_outputs: got clk/rstn/se/tm=%b%b%b%b do=%h tx=%h start=%b busy=%b ovr=%b, expected all 0",
               csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_data_o, tx_data, tx_start, busy, overrun);
    end
    repeat (4) begin @(negedge clk); if (tx_start) starts++; end
    rstn = 1'b1;
    repeat (12) begin @(negedge clk); if (tx_start) starts++; end
    checks++;
    if (starts !== 0) begin errors++; $display("FAIL abort_no_reply: %0d tx_start pulses, expected 0", starts); end
    send_byte(8'h04);
    wait_reply(10, d, lat, seen);
    checks++;
    if (!seen || d !== 8'h00) begin errors++; $display("FAIL abort_status: got %h (seen %0d), expected 00", d, seen); end
  endtask

  initial begin
    test_reset;
    test_mode;
    test_shift;
    test_pulse;
    test_boundary;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csoc_scan_ctrl.md
# csoc_scan_ctrl

Byte-command scan-chain controller for the CSoC test harness. Sits between the UART receiver/transmitter pair and the CSoC test pins. It decodes opcodes from the serial stream and drives `csoc_rstn`, `csoc_test_tm` and `csoc_test_se`. It shifts vectors into `CHAINS` parallel scan chains with a programmable-rate `csoc_clk` and returns every captured vector over the UART.

## Interface
- `CHAINS`, 8: number of parallel scan chains, 1..8; uses bits `[CHAINS-1:0]` of each payload byte.
- `CLK_DIV`, 4: `clk` cycles per `csoc_clk` phase (low, then high), >= 1.
- `clk`  in  1  system clock; sole clock domain.
- `rstn`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  one-cycle transmit strobe.
- `tx_ready`  in  1  transmitter idle.
- `csoc_clk`  out  1  scan/functional clock to CSoC.
- `csoc_rstn`, `csoc_test_se`, `csoc_test_tm`  out  1 each  CSoC reset, scan enable, test mode.
- `csoc_data_o`  out  CHAINS  scan-in bits.
- `csoc_data_i`  in  CHAINS  scan-out bits.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky; a byte arrived while not accepted.

## Operation
- Opcodes:
  - `0x01 MODE m`: `csoc_rstn`=m[2], `csoc_test_se`=m[1], `csoc_test_tm`=m[0]; reply `0xA5`.
  - `0x02 SHIFT nh nl` then N payload bytes, N={nh,nl}. For each byte: drive `csoc_data_o`, issue one `csoc_clk` pulse, reply with the captured byte (zero-extended to 8 bits).
  - `0x03 PULSE nh nl`: N `csoc_clk` pulses, `csoc_data_o` unchanged; reply `0xA5` after the last pulse.
  - `0x04 STATUS`: reply `{overrun,1'b0,busy_at_decode=0,2'b0,rstn,se,tm}` = `{overrun,4'b0,csoc_rstn,csoc_test_se,csoc_test_tm}`; then clear `overrun`.
  - Any other opcode: reply `0xEE`.
- N=0 for SHIFT/PULSE: no pulses, no payload expected; reply `0xA5` immediately.
- States:
  - IDLE: `rx_valid` -> decode.
  - ARG: collects 1 or 2 argument bytes.
  - WAIT_DATA: SHIFT payload.
  - CLK_LO, CLK_HI: pulse phases.
  - SEND: waits for `tx_ready`, then pulses `tx_start`.
  - Next-state after SEND: WAIT_DATA if SHIFT bytes remain, else IDLE.
- Byte acceptance: bytes are consumed only in IDLE, ARG and WAIT_DATA. An `rx_valid` in any other state is dropped and sets `overrun`.
- Counters: 16-bit remaining-count register, decremented after each pulse's CLK_HI phase; phase counter is `$clog2(CLK_DIV+1)` bits.

## Timing
- Reset values: `csoc_clk`=0, `csoc_rstn`=0, `csoc_test_se`=0, `csoc_test_tm`=0, `csoc_data_o`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `overrun`=0; state IDLE.
- Reset asserted mid-operation aborts everything, including pending replies.
- `csoc_data_o` updates on the first cycle of CLK_LO, giving CLK_DIV cycles of setup.
- `csoc_clk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
- `csoc_data_i` is registered on the last CLK_LO cycle, i.e. the same edge on which `csoc_clk` goes high.
- Pulse period is 2*CLK_DIV cycles. PULSE with N pulses lasts 2*CLK_DIV*N cycles, plus reply.
- `tx_start` is high for exactly one cycle, in the first SEND cycle with `tx_ready`=1. `tx_data` is valid that cycle and held until the next reply.
- MODE outputs change one cycle after the `rx_valid` of the mode byte.
- Reply latency from the final command byte (no pulses, `tx_ready`=1): 2 cycles.
- An `rx_valid` arriving on the same cycle the FSM returns to IDLE is accepted, not counted as overrun.

## Configuration
- `CSOC_SCAN_LOOPBACK_EN` defined: the capture source is internal `csoc_data_o` instead of `csoc_data_i`, and `csoc_data_i` is ignored. This gives self-test without a CSoC attached; each SHIFT reply equals its payload masked to CHAINS bits.
- `CSOC_SCAN_LOOPBACK_EN` undefined: capture from `csoc_data_i`.

## Test plan
- Reset, then `0x04` -> reply `0x00`. All CSoC outputs 0 and `busy`=0 after reset.
- `0x01 0x07` -> `csoc_rstn`/`csoc_test_se`/`csoc_test_tm`=1/1/1, reply `0xA5`; then `0x04` -> reply `0x07`.
- CHAINS=4, CLK_DIV=2, `csoc_data_i`=4'hA:
  - `0x02 0x00 0x02 0x3C 0x05` -> two `csoc_clk` pulses of period 4 cycles.
  - `csoc_data_o`=4'hC, then 4'h5.
  - Replies `0x0A`, `0x0A`.
- `0x03 0x01 0x00` -> exactly 256 pulses, `csoc_data_o` unchanged, then reply `0xA5`. A byte injected mid-pulse sets `overrun`; next `0x04` returns bit7=1, and the following `0x04` returns bit7=0.
- `0x7F` -> reply `0xEE`, FSM back in IDLE. `0x02 0x00 0x00` -> reply `0xA5` with no pulses.
- Assert `rstn` low during SHIFT payload -> all outputs return to reset values, no `tx_start`. Under `CSOC_SCAN_LOOPBACK_EN`, payload `0xFF` with CHAINS=8 -> reply `0xFF`.
